// File: rtl/vcve2_vrf_iter_sched.sv
// rtl/vcve2_vrf_iter_sched.sv - Iteration counter, staggered interface start and round-robin token grant
module vcve2_vrf_iter_sched #(
   parameter int NumIfs     = 2,
   parameter int PIPE_WIDTH = 32,
   parameter int CNT_W      = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              req_i,
   input  logic                              abort_i,
   input  logic [31:0]                       vl_i,
   input  logic [1:0]                        sew_i,
   input  logic                              slide_op_i,
   input  logic [31:0]                       slide_offset_i,
   input  logic [NumIfs-1:0]                 req_iter_i,
   output logic [NumIfs-1:0]                 gnt_iter_o,
   output logic                              gnt_last_o,
   input  logic [NumIfs-1:0]                 if_done_i,
   output logic [NumIfs-1:0]                 start_o,
   output logic [$clog2(PIPE_WIDTH/8)-1:0]   offset_o,
   output logic [CNT_W-1:0]                  iter_left_o,
   output logic                              busy_o,
   output logic                              done_o
);

   localparam int BPW    = PIPE_WIDTH / 8;
   localparam int OFFS_W = $clog2(BPW);
   localparam int PTR_W  = (NumIfs > 1) ? $clog2(NumIfs) : 1;
   localparam int STG_W  = $clog2(NumIfs + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic [NumIfs-1:0] started;
   logic [NumIfs-1:0] if_done_q;
   logic [PTR_W-1:0]  ptr;
   logic [STG_W-1:0]  stg;

   logic [31:0]       elems;
   logic [31:0]       bytes;
   logic [OFFS_W-1:0] rem;
   logic [CNT_W-1:0]  count_calc;
   logic [NumIfs-1:0] elig;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  ptr_nxt;
   logic              gnt_any;
   logic              finish;

   // Byte count wraps at 32 bits; a partial final beat rounds the count up.
   always_comb begin
      elems = vl_i;
      if (slide_op_i) begin
         elems = (vl_i > slide_offset_i) ? (vl_i - slide_offset_i) : '0;
      end
      bytes      = elems << sew_i;
      rem        = bytes[OFFS_W-1:0];
      count_calc = CNT_W'(bytes >> OFFS_W) + CNT_W'(rem != '0);
   end

   assign elig = (state == RUN && cnt != '0) ? (req_iter_i & started) : '0;

   // First eligible requester at or after the pointer, wrapping once.
   always_comb begin
      int k;
      k       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int j = 0; j < NumIfs; j++) begin
         k = int'(ptr) + j;
         if (k >= NumIfs) k = k - NumIfs;
         if (!gnt_any && elig[k]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(k);
         end
      end
   end

   assign ptr_nxt     = (gnt_idx == PTR_W'(NumIfs - 1)) ? '0 : gnt_idx + 1'b1;
   assign gnt_iter_o  = gnt_any ? (NumIfs'(1) << gnt_idx) : '0;
   assign gnt_last_o  = gnt_any && (cnt == CNT_W'(1));
   assign iter_left_o = cnt;

   // A done pulse arriving alongside the last token still completes this cycle.
   assign finish = ((cnt == '0) || (gnt_any && cnt == CNT_W'(1))) &&
                   (&(if_done_q | (if_done_i & started)));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         started   <= '0;
         if_done_q <= '0;
         ptr       <= '0;
         stg       <= '0;
         start_o   <= '0;
         offset_o  <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         start_o <= '0;
         done_o  <= 1'b0;
         case (state)
            IDLE: begin
               busy_o <= 1'b0;
               if (req_i && !abort_i) begin
                  cnt       <= count_calc;
                  offset_o  <= rem;
                  ptr       <= '0;
                  if_done_q <= '0;
                  busy_o    <= 1'b1;
                  if (count_calc != '0) begin
                     state   <= RUN;
                     start_o <= NumIfs'(1);
                     started <= NumIfs'(1);
                     stg     <= STG_W'(1);
                  end else begin
                     state   <= DONE;
                     done_o  <= 1'b1;
                     started <= '0;
                     stg     <= '0;
                  end
               end
            end
            RUN: begin
               if (abort_i) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  started   <= '0;
                  if_done_q <= '0;
                  ptr       <= '0;
                  stg       <= '0;
                  offset_o  <= '0;
                  busy_o    <= 1'b0;
               end else begin
                  if (gnt_any) begin
                     cnt <= cnt - CNT_W'(1);
                     ptr <= ptr_nxt;
                  end
                  if_done_q <= if_done_q | (if_done_i & started);
                  if (stg < STG_W'(NumIfs)) begin
                     for (int i = 0; i < NumIfs; i++) begin
                        if (stg == STG_W'(i)) begin
                           start_o[i] <= 1'b1;
                           started[i] <= 1'b1;
                        end
                     end
                     stg <= stg + 1'b1;
                  end
                  if (finish) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               started   <= '0;
               if_done_q <= '0;
               ptr       <= '0;
               stg       <= '0;
               offset_o  <= '0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule
